cdec8_seq: RTL
==============

# cdec8_seq

Microprogram-free control sequencer for the CDEC8 8-bit datapath. It fetches instruction bytes through the datapath's own PC/MAR/RDR path, decodes I, and drives the 15-bit datapath control word each cycle. It sits beside the datapath in the CDEC8 top level. It also exports its state code and halt status to the PC debug monitor and LED resource buses at resource address 0x0B.

## Interface

Parameters: none; all encodings come from `my_const.vh`.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset_N` in 1: synchronous, active-low reset.
- `I` in 8: instruction register from the datapath.
- `SZCy` in 3: flags; [2]=S, [1]=Z, [0]=Cy.
- `run` in 1: sampled only in state F0. 1 = fetch the next instruction; 0 = hold in F0.
- `ctrl` out 15: {mmrw[1:0], fwr, rwr, xdst[2:0], aluop[4:0], xsrc[2:0]}.
- `state` out 8: current state code, for debug resource 0x0B.
- `halt` out 1: high while in HALT.

## Operation

Register, bus and ALU codes:
- xsrc: PC=000, A=001, B=010, C=011, R=100, RDR=101, FLG=110.
- xdst: PC=000, A=001, B=010, C=011, MAR=100, WDR=101, T=110, I=111.
- mmrw: 10 = read (RDR loads), 01 = memory write strobe, 00 = idle.
- aluop: THRX=00h, ADD=01h, SUB=02h, AND=03h, OR=04h, XOR=05h, INC=06h, DEC=07h. The ALU computes XBUS op T.

IDLE control word is 15'h0604: xdst=T, xsrc=R, everything else 0. T is dead except in the cycle right after it is loaded.

Register field r: 00=A, 01=B, 10=C. r=11 in any used field makes the instruction execute as a NOP.

ISA (opcode in I[7:4]; rd=I[3:2], rs=I[1:0]):
- 0 NOP.
- 1 HALT.
- 2 MOV rd,rs.
- 3 LDI rd,#imm.
- 4 LD rd,[a].
- 5 ST rs,[a].
- 6–A ADD/SUB/AND/OR/XOR rd,rs; result rd = rd op rs, flags written.
- B INC rd; C DEC rd (flags written).
- D JMP a.
- E Jcc a; cond = I[1:0]: 00 Z, 01 Cy, 10 S, 11 !Z.
- F: NOP.

States and codes: F0 00, F1 01, F2 02, F3 03, DEC 04, O0 05, O1 06, O2 07, E0 08, E1 09, E2 0A, HALT 0F.

Fetch sequence:
- F0: MAR←PC. If run=0, drive IDLE and stay in F0 instead.
- F1: mmrw=10; R←PC+1 (INC, rwr=1, fwr=0).
- F2: PC←R.
- F3: I←RDR.
- DEC: drive IDLE and branch to the execute path.

Operand fetch (opcodes 3, 4, 5, D, E) runs O0/O1/O2, which are identical to F0/F1/F2 except O0 ignores run. It then continues at E0.

Execute sequences (each returns to F0 when done):
- MOV: E0 rd←rs.
- LDI: E0 rd←RDR.
- LD: E0 MAR←RDR; E1 mmrw=10; E2 rd←RDR.
- ST: E0 MAR←RDR; E1 WDR←rs; E2 mmrw=01 for exactly one cycle.
- ALU ops: E0 T←rs; E1 xsrc=rd, aluop, rwr=fwr=1; E2 rd←R.
- INC/DEC: E0 xsrc=rd, aluop, rwr=fwr=1; E1 rd←R.
- JMP: E0 PC←RDR.
- Jcc: E0 PC←RDR if the condition holds, otherwise IDLE.

HALT drives IDLE and stays in HALT until reset; `halt`=1 there.

## Timing

- ctrl, state and halt are combinational (Moore) from the state register and I. The datapath captures on the next rising edge.
- Reset: while reset_N=0, ctrl=15'h0604, state=00, halt=0. After the first edge with reset_N=0, the state register is F0. A reset mid-instruction abandons it with no memory write. The datapath clears PC itself.
- Cycles from F0 to the next F0:
  - NOP / illegal: 5.
  - MOV: 6.
  - INC/DEC: 7.
  - ALU two-operand: 8.
  - LDI, JMP, Jcc: 9.
  - LD, ST: 11.
- Jcc samples SZCy in E0. The flags reflect the last fwr write, because PC increments never write flags.
- run=0 adds whole cycles in F0 only. An instruction already started always completes.

## Structure

- `my_const.vh` holds:
  - state codes;
  - opcodes and condition codes;
  - xsrc/xdst/aluop/mmrw codes;
  - the IDLE word;
  - a function mapping 2-bit r to a 3-bit register code.
- One natural sub-module: `cdec8_seq_decode`, purely combinational: (state, I, SZCy, run) → (ctrl, next state).
- The top of `cdec8_seq` holds only the 8-bit state register with synchronous reset.

## Test plan

The bench uses the real datapath plus a 256-byte memory model.

1. Hold reset_N=0 for 2 cycles during E1 of an ADD → ctrl=15'h0604, state=00, no mmrw=01 pulse; fetch restarts at PC=00.
2. mem[00]=00 (NOP) → state sequence 00,01,02,03,04,00; PC=01 after 5 cycles; F0 ctrl=15'h0400.
3. Program 30 3C / 34 C4 / 61 → A=3C then B=C4, then ADD gives A=00, SZCy=3'b011; cycle counts 9, 9, 8.
4. Program 50 80 / 48 80 with A=3C → mem[80]=3C with mmrw=01 asserted exactly one cycle (state 0A), then C=3C; each instruction takes 11 cycles.
5. E0 40 at PC=10 with Z=1 → PC=40; same with Z=0 → PC=12; E3 40 with Z=0 → PC=40.
6. Hold run=0 for 4 cycles → state stays 00 with ctrl=15'h0604 and PC unchanged. Then 10 (HALT) → state=0F and halt=1 indefinitely until reset.

Source files
------------

// File: rtl/cdec8_seq_pkg.sv
// Shared encodings for the CDEC8 control sequencer: state codes, opcodes, datapath
// control-word fields and the register-field mapping.
package cdec8_seq_pkg;

  typedef enum logic [7:0] {
    StF0   = 8'h00,
    StF1   = 8'h01,
    StF2   = 8'h02,
    StF3   = 8'h03,
    StDec  = 8'h04,
    StO0   = 8'h05,
    StO1   = 8'h06,
    StO2   = 8'h07,
    StE0   = 8'h08,
    StE1   = 8'h09,
    StE2   = 8'h0A,
    StHalt = 8'h0F
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpHalt = 4'h1;
  localparam logic [3:0] OpMov  = 4'h2;
  localparam logic [3:0] OpLdi  = 4'h3;
  localparam logic [3:0] OpLd   = 4'h4;
  localparam logic [3:0] OpSt   = 4'h5;
  localparam logic [3:0] OpAdd  = 4'h6;
  localparam logic [3:0] OpSub  = 4'h7;
  localparam logic [3:0] OpAnd  = 4'h8;
  localparam logic [3:0] OpOr   = 4'h9;
  localparam logic [3:0] OpXor  = 4'hA;
  localparam logic [3:0] OpInc  = 4'hB;
  localparam logic [3:0] OpDec  = 4'hC;
  localparam logic [3:0] OpJmp  = 4'hD;
  localparam logic [3:0] OpJcc  = 4'hE;

  localparam logic [1:0] CondZ  = 2'b00;
  localparam logic [1:0] CondCy = 2'b01;
  localparam logic [1:0] CondS  = 2'b10;
  localparam logic [1:0] CondNz = 2'b11;

  localparam logic [2:0] SrcPc  = 3'b000;
  localparam logic [2:0] SrcR   = 3'b100;
  localparam logic [2:0] SrcRdr = 3'b101;

  localparam logic [2:0] DstPc  = 3'b000;
  localparam logic [2:0] DstMar = 3'b100;
  localparam logic [2:0] DstWdr = 3'b101;
  localparam logic [2:0] DstT   = 3'b110;
  localparam logic [2:0] DstI   = 3'b111;

  localparam logic [1:0] MmIdle  = 2'b00;
  localparam logic [1:0] MmRead  = 2'b10;
  localparam logic [1:0] MmWrite = 2'b01;

  localparam logic [4:0] AluThrx = 5'h00;
  localparam logic [4:0] AluInc  = 5'h06;

  localparam logic [1:0] RegNone = 2'b11;

  typedef struct packed {
    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [2:0] xdst;
    logic [4:0] aluop;
    logic [2:0] xsrc;
  } ctrl_t;

  // T is only live right after it is written, so parking xdst on T is harmless.
  localparam ctrl_t CtrlIdle = '{mmrw: MmIdle, fwr: 1'b0, rwr: 1'b0, xdst: DstT,
                                 aluop: AluThrx, xsrc: SrcR};

  // r field 00/01/10 selects A/B/C, whose bus codes are 001/010/011.
  function automatic logic [2:0] reg_code(input logic [1:0] r);
    return {1'b0, r} + 3'd1;
  endfunction

endpackage

// File: rtl/cdec8_seq_decode.sv
// Combinational decoder: current state, instruction and flags to control word and
// next state.
module cdec8_seq_decode
  import cdec8_seq_pkg::*;
(
  input  state_e      state,
  input  logic [7:0]  I,
  input  logic [2:0]  SZCy,
  input  logic        run,
  output ctrl_t       ctrl,
  output state_e      next_state
);

  logic [3:0] opcode;
  logic [2:0] rd_code, rs_code;
  logic [3:0] op_rel;
  logic [4:0] alu_op;
  logic       nop_r, cond_ok, need_operand;

  assign opcode  = I[7:4];
  assign rd_code = reg_code(I[3:2]);
  assign rs_code = reg_code(I[1:0]);
  // ALU opcodes 6..C map onto ALU codes 1..7 in order.
  assign op_rel  = opcode - 4'd5;
  assign alu_op  = {1'b0, op_rel};

  assign need_operand = (opcode == OpLdi) || (opcode == OpLd) || (opcode == OpSt) ||
                        (opcode == OpJmp) || (opcode == OpJcc);

  always_comb begin
    nop_r = 1'b0;
    case (opcode)
      OpMov, OpAdd, OpSub, OpAnd, OpOr, OpXor:
        nop_r = (I[3:2] == RegNone) || (I[1:0] == RegNone);
      OpLdi, OpLd, OpInc, OpDec: nop_r = (I[3:2] == RegNone);
      OpSt:                      nop_r = (I[1:0] == RegNone);
      default:                   nop_r = 1'b0;
    endcase
  end

  always_comb begin
    cond_ok = 1'b0;
    unique case (I[1:0])
      CondZ:   cond_ok = SZCy[1];
      CondCy:  cond_ok = SZCy[0];
      CondS:   cond_ok = SZCy[2];
      CondNz:  cond_ok = !SZCy[1];
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctrl       = CtrlIdle;
    next_state = StF0;
    unique case (state)
      StF0: begin
        if (run) begin
          ctrl.xdst  = DstMar;
          ctrl.xsrc  = SrcPc;
          next_state = StF1;
        end
      end
      StF1, StO1: begin
        ctrl.mmrw  = MmRead;
        ctrl.xsrc  = SrcPc;
        ctrl.aluop = AluInc;
        ctrl.rwr   = 1'b1;
        next_state = (state == StF1) ? StF2 : StO2;
      end
      StF2, StO2: begin
        ctrl.xdst  = DstPc;
        ctrl.xsrc  = SrcR;
        next_state = (state == StF2) ? StF3 : StE0;
      end
      StF3: begin
        ctrl.xdst  = DstI;
        ctrl.xsrc  = SrcRdr;
        next_state = StDec;
      end
      StDec: begin
        if (nop_r || opcode == OpNop || opcode == 4'hF) next_state = StF0;
        else if (opcode == OpHalt)                      next_state = StHalt;
        else if (need_operand)                          next_state = StO0;
        else                                            next_state = StE0;
      end
      StO0: begin
        ctrl.xdst  = DstMar;
        ctrl.xsrc  = SrcPc;
        next_state = StO1;
      end
      StE0: begin
        case (opcode)
          OpMov: begin
            ctrl.xdst = rd_code;
            ctrl.xsrc = rs_code;
          end
          OpLdi: begin
            ctrl.xdst = rd_code;
            ctrl.xsrc = SrcRdr;
          end
          OpLd, OpSt: begin
            ctrl.xdst  = DstMar;
            ctrl.xsrc  = SrcRdr;
            next_state = StE1;
          end
          OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            ctrl.xdst  = DstT;
            ctrl.xsrc  = rs_code;
            next_state = StE1;
          end
          OpInc, OpDec: begin
            ctrl.xsrc  = rd_code;
            ctrl.aluop = alu_op;
            ctrl.rwr   = 1'b1;
            ctrl.fwr   = 1'b1;
            next_state = StE1;
          end
          OpJmp: begin
            ctrl.xdst = DstPc;
            ctrl.xsrc = SrcRdr;
          end
          OpJcc: begin
            if (cond_ok) begin
              ctrl.xdst = DstPc;
              ctrl.xsrc = SrcRdr;
            end
          end
          default: ;
        endcase
      end
      StE1: begin
        case (opcode)
          OpLd: begin
            ctrl.mmrw  = MmRead;
            next_state = StE2;
          end
          OpSt: begin
            ctrl.xdst  = DstWdr;
            ctrl.xsrc  = rs_code;
            next_state = StE2;
          end
          OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            ctrl.xsrc  = rd_code;
            ctrl.aluop = alu_op;
            ctrl.rwr   = 1'b1;
            ctrl.fwr   = 1'b1;
            next_state = StE2;
          end
          OpInc, OpDec: begin
            ctrl.xdst = rd_code;
            ctrl.xsrc = SrcR;
          end
          default: ;
        endcase
      end
      StE2: begin
        case (opcode)
          OpLd: begin
            ctrl.xdst = rd_code;
            ctrl.xsrc = SrcRdr;
          end
          OpSt: ctrl.mmrw = MmWrite;
          OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            ctrl.xdst = rd_code;
            ctrl.xsrc = SrcR;
          end
          default: ;
        endcase
      end
      StHalt:  next_state = StHalt;
      default: next_state = StF0;
    endcase
  end

endmodule

// File: rtl/cdec8_seq.sv
// CDEC8 control sequencer top: state register with synchronous reset; outputs are
// forced to the idle word while reset is held so no memory write can escape.
module cdec8_seq
  import cdec8_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset_N,
  input  logic [7:0]  I,
  input  logic [2:0]  SZCy,
  input  logic        run,
  output logic [14:0] ctrl,
  output logic [7:0]  state,
  output logic        halt
);

  state_e state_q, state_d;
  ctrl_t  dec_ctrl;

  cdec8_seq_decode u_decode (
    .state      (state_q),
    .I          (I),
    .SZCy       (SZCy),
    .run        (run),
    .ctrl       (dec_ctrl),
    .next_state (state_d)
  );

  always_ff @(posedge clock) begin
    if (!reset_N) state_q <= StF0;
    else          state_q <= state_d;
  end

  assign ctrl  = reset_N ? dec_ctrl : CtrlIdle;
  assign state = reset_N ? state_q : StF0;
  assign halt  = reset_N && (state_q == StHalt);

endmodule
